// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// Latency: XLEN+1 cycles (W: XLEN/2+1), divide-by-zero/overflow 1 cycle; response held until resp_ready.
// Backpressure: req_ready only in IDLE without flush; result and tag frozen while resp_valid & !resp_ready.
module div_sequencer #(
    parameter int TAG_WIDTH = 6,
    parameter int XLEN      = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_src1,
    input  logic [XLEN-1:0]      req_src2,
    input  logic [1:0]           req_op,
    input  logic                 req_is_word,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_result,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic                 busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int HW = XLEN / 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   rdy_en;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [XLEN-1:0]        result_q;
    logic [XLEN-1:0]        quo_q, rem_q, dvs_q;
    logic [CW-1:0]          cnt_q;
    logic                   word_q, sel_rem_q, neg_q_q, neg_r_q;

    // W forms keep their result in the low half; both signednesses sign-extend it
    function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v, input logic w);
        finalize = w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    logic            accept, signed_op, sgn1, sgn2, div0, ovf, special;
    logic [XLEN-1:0] src1_ext, src2_ext, abs1, abs2, min_neg, spec_res;

    always_comb begin
        accept    = req_valid & req_ready;
        signed_op = ~req_op[0];
        src1_ext  = req_src1;
        src2_ext  = req_src2;
        if (req_is_word) begin
            src1_ext = signed_op ? {{HW{req_src1[HW-1]}}, req_src1[HW-1:0]} : {{HW{1'b0}}, req_src1[HW-1:0]};
            src2_ext = signed_op ? {{HW{req_src2[HW-1]}}, req_src2[HW-1:0]} : {{HW{1'b0}}, req_src2[HW-1:0]};
        end
        sgn1     = signed_op & src1_ext[XLEN-1];
        sgn2     = signed_op & src2_ext[XLEN-1];
        abs1     = sgn1 ? -src1_ext : src1_ext;
        abs2     = sgn2 ? -src2_ext : src2_ext;
        min_neg  = req_is_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div0     = (src2_ext == '0);
        ovf      = signed_op & (src1_ext == min_neg) & (src2_ext == '1);
        special  = div0 | ovf;
        spec_res = '0;
        if (div0)
            spec_res = finalize(req_op[1] ? src1_ext : '1, req_is_word);
        else if (!req_op[1])
            spec_res = finalize(src1_ext, req_is_word);
    end

    // One restoring step: shift remainder:quotient, trial-subtract, keep if non-negative
    logic [XLEN:0]   rem_shift, rem_diff;
    logic            ge;
    logic [XLEN-1:0] quo_step, rem_step, quo_fix, rem_fix, fix_res;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        ge        = (rem_shift >= {1'b0, dvs_q});
        rem_step  = ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], ge};
        quo_fix   = neg_q_q ? -quo_step : quo_step;
        rem_fix   = neg_r_q ? -rem_step : rem_step;
        fix_res   = finalize(sel_rem_q ? rem_fix : quo_fix, word_q);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
            BUSY:    if (cnt_q == CW'(1)) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rdy_en <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q     <= '0;
            result_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            word_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else if (accept) begin
            tag_q     <= req_tag;
            word_q    <= req_is_word;
            sel_rem_q <= req_op[1];
            neg_q_q   <= sgn1 ^ sgn2;
            neg_r_q   <= sgn1;
            dvs_q     <= abs2;
            rem_q     <= '0;
            // W dividend sits in the top half so quotient bits land in the low half
            quo_q     <= req_is_word ? {abs1[HW-1:0], {HW{1'b0}}} : abs1;
            cnt_q     <= req_is_word ? CW'(HW) : CW'(XLEN);
            if (special) result_q <= spec_res;
        end else if (state == BUSY) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) result_q <= fix_res;
        end
    end

    assign req_ready   = (state == IDLE) & ~flush & rdy_en;
    assign resp_valid  = (state == DONE);
    assign resp_result = result_q;
    assign resp_tag    = tag_q;
    assign busy        = (state != IDLE);
endmodule
